pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed 32-bit write-enabled register.
- Serves as the generic inter-stage latch for the pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake with a 2-entry skid buffer, so InReady has no combinational path from OutReady.
- Also adds synchronous flush for bubble insertion, an occupancy output and a wrapping transfer counter.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into both data registers on reset.
- CNT_W, 16, width of TransferCount (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clk).
- InData  input  WIDTH  upstream payload.
- InValid  input  1  upstream payload valid.
- InReady  output  1  stage can accept; function of state only.
- OutData  output  WIDTH  payload to downstream; always driven from the main register.
- OutValid  output  1  main register holds valid data.
- OutReady  input  1  downstream accepts.
- Flush  input  1  synchronous discard of all held and incoming data.
- Occupancy  output  2  number of entries held (0, 1 or 2).
- TransferCount  output  CNT_W  count of completed output transfers; wraps modulo 2^CNT_W.

Behaviour:
- Definitions:
  - Input transfer: InValid & InReady at a rising edge.
  - Output transfer: OutValid & OutReady at a rising edge.
- Storage: main register M (drives OutData) and skid register S.
- State machine:
  - States: EMPTY (Occupancy 0), ONE (1), TWO (2).
  - Combinational outputs: OutValid = (state != EMPTY); InReady = (state != TWO).
  - No combinational path from any input to any output.
- Transitions, applied when reset=1 and Flush=0:
  - EMPTY: input transfer -> ONE, M<=InData; otherwise remain EMPTY.
  - ONE, input & output transfer -> ONE, M<=InData (back-to-back streaming, full throughput).
  - ONE, input only -> TWO, S<=InData, M unchanged.
  - ONE, output only -> EMPTY.
  - ONE, neither -> hold.
  - TWO, output transfer -> ONE, M<=S.
  - TWO, no output transfer -> hold. InReady=0, so no input transfer is possible.
- Ordering is FIFO: payloads appear on OutData in input-transfer order, with no loss and no duplication.
- Flush=1 (reset=1):
  - Next state is EMPTY.
  - Any input transfer in the same cycle is discarded.
  - An output transfer in the same cycle counts as completed and increments TransferCount.
  - M and S are not cleared. OutData keeps its last value, but OutValid=0 from the next cycle.
- Reset (reset=0 at an edge):
  - Overrides Flush and all handshakes.
  - State EMPTY, M<=RESET_VALUE, S<=RESET_VALUE, TransferCount<=0.
  - After reset: OutValid=0, InReady=1, Occupancy=0, OutData=RESET_VALUE.
  - Reset asserted mid-stream drops all held entries; no transfer is counted in the reset cycle.
- TransferCount increments by 1 on each output transfer (reset=1) and wraps from 2^CNT_W-1 to 0.
- Data while OutValid=0 is don't-care for consumers but must equal the last value held in M.
- Latency: 1 cycle input-to-OutValid when EMPTY. Sustained throughput is 1 transfer/cycle while OutReady=1.

Test Plan:
- Reset then idle: hold reset=0 for 2 edges, release -> OutValid=0, InReady=1, Occupancy=0, OutData=RESET_VALUE, TransferCount=0.
- Streaming: OutReady=1, push 0x11,0x22,0x33 on consecutive cycles -> OutData shows 0x11,0x22,0x33 on cycles 1-3, Occupancy stays 1, TransferCount=3.
- Backpressure/skid: OutReady=0, push 0xA1,0xA2 -> Occupancy=2, InReady=0; 0xA3 held on InData is not accepted. Then OutReady=1 for 3 cycles -> outputs 0xA1,0xA2,0xA3 in order.
- Flush in TWO with a simultaneous output transfer and InValid=1 (0xBB) -> next cycle Occupancy=0, OutValid=0, TransferCount +1, and 0xBB never appears.
- Reset mid-stream with Occupancy=2 and Flush=1 -> EMPTY, OutData=RESET_VALUE, TransferCount=0.
- Counter wrap: CNT_W=2, perform 5 output transfers -> TransferCount sequence 1,2,3,0,1.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream/downstream valid-ready plus flush and status.
// master = environment side, slave = stage side.
interface pipe_stage_reg_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] InData;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] OutData;
  logic             OutValid;
  logic             OutReady;
  logic             Flush;
  logic [1:0]       Occupancy;
  logic [CNT_W-1:0] TransferCount;

  modport master (
    output InData, InValid, OutReady, Flush,
    input  InReady, OutData, OutValid, Occupancy, TransferCount
  );

  modport slave (
    input  InData, InValid, OutReady, Flush,
    output InReady, OutData, OutValid, Occupancy, TransferCount
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage latch with 2-entry skid buffer, flush, occupancy and transfer counter.
// Latency 1 cycle when empty; InReady depends on state only so upstream never sees OutReady.
module pipe_stage_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter int               CNT_W       = 16
) (
  input logic             clk,
  input logic             reset,
  pipe_stage_reg_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic in_ready;
  logic out_valid;
  logic in_xfer;
  logic out_xfer;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign in_xfer   = bus.InValid & in_ready;
  assign out_xfer  = out_valid & bus.OutReady;

  assign bus.InReady       = in_ready;
  assign bus.OutValid      = out_valid;
  assign bus.OutData       = m_q;
  assign bus.Occupancy     = state_q;
  assign bus.TransferCount = cnt_q;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    cnt_d   = cnt_q;

    // A transfer completing in a flush cycle still counts.
    if (out_xfer) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (bus.Flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = ONE;
            m_d     = bus.InData;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            m_d = bus.InData;
          end else if (in_xfer) begin
            state_d = TWO;
            s_d     = bus.InData;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            state_d = ONE;
            m_d     = s_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
      m_q     <= RESET_VALUE;
      s_q     <= RESET_VALUE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
